// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state encoding, default vectors and alignment helper for pc_unit
package pc_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0080;

   // Mask that clears the low log2(inc) bits; inc is a power of two.
   function automatic logic [63:0] align_mask(input int unsigned inc);
      return ~(64'(inc) - 64'd1);
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/status bundle between next-PC logic and pc_unit
interface pc_unit_if #(parameter int unsigned XLEN = 32);

   logic            stall;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;
   logic            call_req;
   logic            ret_req;
   logic            trap_req;
   logic            halt_req;
   logic            resume;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus;
   logic            pc_valid;
   logic            halted;
   logic            ras_empty;
   logic            ras_overflow;

   modport master (
      output stall, redirect_valid, redirect_target, call_req, ret_req,
             trap_req, halt_req, resume,
      input  pc_out, pc_plus, pc_valid, halted, ras_empty, ras_overflow
   );

   modport slave (
      input  stall, redirect_valid, redirect_target, call_req, ret_req,
             trap_req, halt_req, resume,
      output pc_out, pc_plus, pc_valid, halted, ras_empty, ras_overflow
   );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full drops the oldest entry
module pc_ras #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty,
   output logic            overflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   top_idx;
   logic            full;

   assign full     = (count_q == CW'(RAS_DEPTH));
   assign empty    = (count_q == '0);
   assign overflow = ovf_q;
   assign top_idx  = wptr_q - PW'(1);
   assign top      = mem_q[top_idx];

   // The write pointer wraps naturally because the depth is a power of two.
   always_comb begin
      wptr_d  = wptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push) begin
         wptr_d = wptr_q + PW'(1);
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (pop && !empty) begin
         wptr_d  = wptr_q - PW'(1);
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with boot/run/halt sequencing, redirects, traps and RAS
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     INC          = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   pc_unit_if.slave   bus
);

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INC));

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus;
   logic            ras_push, ras_pop;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty, ras_overflow;

   assign pc_plus = pc_q + XLEN'(INC);

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_plus),
      .top       (ras_top),
      .empty     (ras_empty),
      .overflow  (ras_overflow)
   );

   // RUN decisions follow a fixed priority: trap, halt, redirect, return, stall, step.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.trap_req) begin
               pc_d = TRAP_VECTOR;
            end else if (bus.halt_req) begin
               state_d = ST_HALT;
            end else if (bus.redirect_valid) begin
               pc_d     = bus.redirect_target & ALIGN_MASK;
               ras_push = bus.call_req;
            end else if (bus.ret_req) begin
               if (!ras_empty) begin
                  pc_d    = ras_top;
                  ras_pop = 1'b1;
               end else begin
                  pc_d = pc_plus;
               end
            end else if (!bus.stall) begin
               pc_d = pc_plus;
            end
         end
         ST_HALT: begin
            if (bus.trap_req) begin
               pc_d    = TRAP_VECTOR;
               state_d = ST_RUN;
            end else if (bus.resume) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
            pc_d    = RESET_VECTOR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign bus.pc_out       = pc_q;
   assign bus.pc_plus      = pc_plus;
   assign bus.pc_valid     = (state_q == ST_RUN);
   assign bus.halted       = (state_q == ST_HALT);
   assign bus.ras_empty    = ras_empty;
   assign bus.ras_overflow = ras_overflow;

endmodule
